// File: rtl/psm_pattern_gen.sv
// Open-loop pulse-skip modulator: internal PWM counter, passes pass_sh periods then skips skip_sh.
// Optional skipped-period counter output enabled by defining PSM_SKIP_CNT_EN.
module psm_pattern_gen #(
  parameter int RESOLUTION = 8,
  parameter int PAT_WIDTH  = 4,
  parameter int SKIP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [RESOLUTION:0]   duty_cfg,
  input  logic [PAT_WIDTH-1:0]  pass_cfg,
  input  logic [PAT_WIDTH-1:0]  skip_cfg,
  output logic                  psm_out,
  output logic                  pwm_out,
  output logic                  period_start,
  output logic                  skip_active
`ifdef PSM_SKIP_CNT_EN
  ,
  output logic [SKIP_CNT_W-1:0] skip_count
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [RESOLUTION:0]   DUTY_FULL = {1'b1, {RESOLUTION{1'b0}}};
  localparam logic [RESOLUTION-1:0] CNT_MAX   = '1;

  state_t                state;
  logic [RESOLUTION-1:0] cnt;
  logic [PAT_WIDTH:0]    pat;
  logic [RESOLUTION:0]   duty_sh;
  logic [PAT_WIDTH-1:0]  pass_sh;
  logic [PAT_WIDTH-1:0]  skip_sh;

  logic [RESOLUTION:0]   duty_clamped;
  logic [PAT_WIDTH:0]    pat_len;
  logic                  pass_all;
  logic                  in_skip;
  logic                  pwm_now;
  logic                  cnt_wrap;
  logic                  pat_wrap;

  // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    duty_clamped = (duty_cfg > DUTY_FULL) ? DUTY_FULL : duty_cfg;
    pat_len      = {1'b0, pass_sh} + {1'b0, skip_sh};
    // An empty pattern (pass=skip=0) means pass every period.
    pass_all     = (pat_len == '0);
    in_skip      = !pass_all && (pat >= {1'b0, pass_sh});
    pwm_now      = ({1'b0, cnt} < duty_sh);
    cnt_wrap     = (cnt == CNT_MAX);
    pat_wrap     = pass_all || (pat == pat_len - (PAT_WIDTH+1)'(1));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pat          <= '0;
      duty_sh      <= '0;
      pass_sh      <= '0;
      skip_sh      <= '0;
      psm_out      <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      skip_active  <= 1'b0;
`ifdef PSM_SKIP_CNT_EN
      skip_count   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state   <= RUN;
            cnt     <= '0;
            pat     <= '0;
            duty_sh <= duty_clamped;
            pass_sh <= pass_cfg;
            skip_sh <= skip_cfg;
          end
        end
        RUN: begin
          if (!en) begin
            // Dropping enable wins over any wrap on the same edge: no shadow load.
            state        <= IDLE;
            cnt          <= '0;
            pat          <= '0;
            psm_out      <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            skip_active  <= 1'b0;
`ifdef PSM_SKIP_CNT_EN
            skip_count   <= '0;
`endif
          end else begin
            pwm_out      <= pwm_now;
            psm_out      <= pwm_now && !in_skip;
            period_start <= (cnt == '0);
            skip_active  <= in_skip;
            cnt          <= cnt + 1'b1;
            if (cnt_wrap) begin
              duty_sh <= duty_clamped;
              if (pat_wrap) begin
                pat     <= '0;
                pass_sh <= pass_cfg;
                skip_sh <= skip_cfg;
              end else begin
                pat <= pat + 1'b1;
              end
`ifdef PSM_SKIP_CNT_EN
              if (in_skip && (skip_count != '1))
                skip_count <= skip_count + 1'b1;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psm_pattern_gen.sv
// Self-checking bench for psm_pattern_gen at RESOLUTION=4 (16-clk period).
// A period-level reference model predicts every output cycle; directed tasks add pulse-count checks.
module tb_psm_pattern_gen;

  localparam int RES = 4;
  localparam int PW  = 4;
  localparam int P   = 1 << RES;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [RES:0]  duty_cfg = '0;
  logic [PW-1:0] pass_cfg = '0;
  logic [PW-1:0] skip_cfg = '0;
  logic          psm_out, pwm_out, period_start, skip_active;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: position within period, period index within pattern, latched settings.
  bit          m_run = 1'b0;
  int          m_k = 0, m_pidx = 0, m_duty = 0, m_pass = 0, m_skip = 0;
  logic        e_psm = 1'b0, e_pwm = 1'b0, e_ps = 1'b0, e_sa = 1'b0;
  logic [15:0] e_skc = '0;

`ifdef PSM_SKIP_CNT_EN
  logic [15:0] skip_count;
  wire  [19:0] got   = {psm_out, pwm_out, period_start, skip_active, skip_count};
  wire  [19:0] exp_v = {e_psm, e_pwm, e_ps, e_sa, e_skc};
`else
  wire  [3:0]  got   = {psm_out, pwm_out, period_start, skip_active};
  wire  [3:0]  exp_v = {e_psm, e_pwm, e_ps, e_sa};
`endif

  psm_pattern_gen #(.RESOLUTION(RES), .PAT_WIDTH(PW), .SKIP_CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .duty_cfg     (duty_cfg),
    .pass_cfg     (pass_cfg),
    .skip_cfg     (skip_cfg),
    .psm_out      (psm_out),
    .pwm_out      (pwm_out),
    .period_start (period_start),
`ifdef PSM_SKIP_CNT_EN
    .skip_count   (skip_count),
`endif
    .skip_active  (skip_active)
  );

  always #5 clk = ~clk;

  function automatic int clamp_duty(int d);
    return (d > P) ? P : d;
  endfunction

  always @(posedge clk or negedge rst_n) begin : ref_model
    int len;
    bit skipped;
    if (!rst_n) begin
      m_run = 1'b0; m_k = 0; m_pidx = 0; m_duty = 0; m_pass = 0; m_skip = 0;
      {e_psm, e_pwm, e_ps, e_sa} = '0;
      e_skc = '0;
    end else if (!m_run) begin
      {e_psm, e_pwm, e_ps, e_sa} = '0;
      if (en) begin
        m_run = 1'b1; m_k = 0; m_pidx = 0;
        m_duty = clamp_duty(int'(duty_cfg));
        m_pass = int'(pass_cfg);
        m_skip = int'(skip_cfg);
      end
    end else if (!en) begin
      m_run = 1'b0;
      {e_psm, e_pwm, e_ps, e_sa} = '0;
      e_skc = '0;
    end else begin
      len     = m_pass + m_skip;
      skipped = (len != 0) && (m_pidx >= m_pass);
      e_pwm   = (m_k < m_duty);
      e_psm   = e_pwm && !skipped;
      e_ps    = (m_k == 0);
      e_sa    = skipped;
      m_k++;
      if (m_k == P) begin
        m_k = 0;
        if (skipped && e_skc != 16'hFFFF) e_skc++;
        m_duty = clamp_duty(int'(duty_cfg));
        m_pidx++;
        if (len == 0 || m_pidx >= len) begin
          m_pidx = 0;
          m_pass = int'(pass_cfg);
          m_skip = int'(skip_cfg);
        end
      end
    end
  end

  task automatic go_idle();
    en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_state got=%h exp=0", got); end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL idle_after_reset c=%0d got=%h exp=%h", c, got, exp_v); end
    end
  endtask

  task automatic test_basic();
    int pwm_hi = 0, psm_hi = 0, ps_hi = 0;
    duty_cfg = 8; pass_cfg = 1; skip_cfg = 0; en = 1'b1;
    for (int c = 0; c <= 48; c++) begin
      @(negedge clk);
      n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL basic c=%0d got=%h exp=%h", c, got, exp_v); end
      if (c == 0) begin
        n_tests++;
        if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL basic_early_out got=%b exp=0", pwm_out); end
      end
      if (c == 1) begin
        n_tests++;
        if ({pwm_out, period_start} !== 2'b11) begin n_fail++; $display("FAIL basic_first_out got=%b exp=11", {pwm_out, period_start}); end
      end
      if (c >= 1) begin pwm_hi += int'(pwm_out); psm_hi += int'(psm_out); ps_hi += int'(period_start); end
    end
    n_tests++; if (pwm_hi != 24) begin n_fail++; $display("FAIL basic_pwm_high got=%0d exp=24", pwm_hi); end
    n_tests++; if (psm_hi != 24) begin n_fail++; $display("FAIL basic_psm_high got=%0d exp=24", psm_hi); end
    n_tests++; if (ps_hi != 3)   begin n_fail++; $display("FAIL basic_period_start got=%0d exp=3", ps_hi); end
    go_idle();
  endtask

  task automatic test_pattern();
    int psm_hi = 0, sa_hi = 0;
    duty_cfg = 4; pass_cfg = 2; skip_cfg = 3; en = 1'b1;
    for (int c = 0; c <= 160; c++) begin
      @(negedge clk);
      n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL pattern c=%0d got=%h exp=%h", c, got, exp_v); end
      if (c >= 1) begin psm_hi += int'(psm_out); sa_hi += int'(skip_active); end
`ifdef PSM_SKIP_CNT_EN
      if (c == 80) begin
        n_tests++;
        if (skip_count !== 16'd3) begin n_fail++; $display("FAIL pattern_skip_count1 got=%0d exp=3", skip_count); end
      end
      if (c == 160) begin
        n_tests++;
        if (skip_count !== 16'd6) begin n_fail++; $display("FAIL pattern_skip_count2 got=%0d exp=6", skip_count); end
      end
`endif
    end
    n_tests++; if (psm_hi != 16) begin n_fail++; $display("FAIL pattern_psm_high got=%0d exp=16", psm_hi); end
    n_tests++; if (sa_hi != 96)  begin n_fail++; $display("FAIL pattern_skip_active got=%0d exp=96", sa_hi); end
    go_idle();
  endtask

  task automatic test_shadow();
    int p0 = 0, p1 = 0, psm_hi = 0, sa_hi = 0;
    duty_cfg = 4; pass_cfg = 2; skip_cfg = 2; en = 1'b1;
    for (int c = 0; c <= 128; c++) begin
      @(negedge clk);
      n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL shadow c=%0d got=%h exp=%h", c, got, exp_v); end
      if (c >= 1 && c <= 16) p0 += int'(psm_out);
      if (c >= 17 && c <= 32) p1 += int'(psm_out);
      if (c >= 1) begin psm_hi += int'(psm_out); sa_hi += int'(skip_active); end
      if (c == 5) duty_cfg = 12;
      if (c == 20) begin pass_cfg = 1; skip_cfg = 3; end
    end
    n_tests++; if (p0 != 4)      begin n_fail++; $display("FAIL shadow_duty_cur got=%0d exp=4", p0); end
    n_tests++; if (p1 != 12)     begin n_fail++; $display("FAIL shadow_duty_next got=%0d exp=12", p1); end
    n_tests++; if (psm_hi != 28) begin n_fail++; $display("FAIL shadow_psm_high got=%0d exp=28", psm_hi); end
    n_tests++; if (sa_hi != 80)  begin n_fail++; $display("FAIL shadow_skip_active got=%0d exp=80", sa_hi); end
    go_idle();
  endtask

  typedef struct {
    int duty; int pass; int skip; int psm; int pwm; int sa;
  } bcase_t;

  task automatic test_boundaries();
    bcase_t cases[6] = '{
      '{0, 1, 1, 0, 0, 32},
      '{16, 1, 1, 32, 64, 32},
      '{20, 1, 1, 32, 64, 32},
      '{8, 0, 2, 0, 32, 64},
      '{8, 0, 0, 32, 32, 0},
      '{8, 3, 0, 32, 32, 0}
    };
    foreach (cases[i]) begin
      int psm_hi = 0, pwm_hi = 0, sa_hi = 0;
      duty_cfg = (RES+1)'(cases[i].duty);
      pass_cfg = PW'(cases[i].pass);
      skip_cfg = PW'(cases[i].skip);
      en = 1'b1;
      for (int c = 0; c <= 64; c++) begin
        @(negedge clk);
        n_tests++;
        if (got !== exp_v) begin n_fail++; $display("FAIL boundary%0d c=%0d got=%h exp=%h", i, c, got, exp_v); end
        if (c >= 1) begin psm_hi += int'(psm_out); pwm_hi += int'(pwm_out); sa_hi += int'(skip_active); end
      end
      n_tests++; if (psm_hi != cases[i].psm) begin n_fail++; $display("FAIL boundary%0d_psm got=%0d exp=%0d", i, psm_hi, cases[i].psm); end
      n_tests++; if (pwm_hi != cases[i].pwm) begin n_fail++; $display("FAIL boundary%0d_pwm got=%0d exp=%0d", i, pwm_hi, cases[i].pwm); end
      n_tests++; if (sa_hi != cases[i].sa)   begin n_fail++; $display("FAIL boundary%0d_sa got=%0d exp=%0d", i, sa_hi, cases[i].sa); end
      go_idle();
    end
  endtask

  task automatic test_en_drop();
    duty_cfg = 8; pass_cfg = 1; skip_cfg = 0; en = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL en_drop c=%0d got=%h exp=%h", c, got, exp_v); end
    end
    n_tests++;
    if (psm_out !== 1'b1) begin n_fail++; $display("FAIL en_drop_pre got=%b exp=1", psm_out); end
    en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (got !== '0) begin n_fail++; $display("FAIL en_drop_outputs got=%h exp=0", got); end
    en = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL en_restart c=%0d got=%h exp=%h", c, got, exp_v); end
      if (c == 1) begin
        n_tests++;
        if ({period_start, pwm_out} !== 2'b11) begin n_fail++; $display("FAIL en_restart_first got=%b exp=11", {period_start, pwm_out}); end
      end
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    duty_cfg = 8; pass_cfg = 1; skip_cfg = 1; en = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL areset_pre c=%0d got=%h exp=%h", c, got, exp_v); end
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (got !== '0) begin n_fail++; $display("FAIL areset_immediate got=%h exp=0", got); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL areset_restart c=%0d got=%h exp=%h", c, got, exp_v); end
      if (c == 1) begin
        n_tests++;
        if (period_start !== 1'b1) begin n_fail++; $display("FAIL areset_first got=%b exp=1", period_start); end
      end
    end
    go_idle();
  endtask

  task automatic test_random();
    en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL random c=%0d got=%h exp=%h", c, got, exp_v); end
      if (en ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 20)) en = ~en;
      if ($urandom_range(0, 99) < 5) begin
        duty_cfg = (RES+1)'($urandom_range(0, 20));
        pass_cfg = PW'($urandom_range(0, 3));
        skip_cfg = PW'($urandom_range(0, 3));
      end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pattern();
    test_shadow();
    test_boundaries();
    test_en_drop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
